// File: rtl/fpu_unit_arbiter.sv
// fpu_unit_arbiter: two-requester round-robin arbiter sharing one FPU
// conversion unit. One transaction runs at a time: accept an operand from
// the granted requester, issue it to the unit, collect the result and
// hand it back to that same requester. All handshake outputs are registered.
module fpu_unit_arbiter #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       input_a,
  input  logic                   input_a_stb,
  output logic                   input_a_ack,
  input  logic [WIDTH-1:0]       input_b,
  input  logic                   input_b_stb,
  output logic                   input_b_ack,
  output logic [WIDTH-1:0]       output_a,
  output logic                   output_a_stb,
  input  logic                   output_a_ack,
  output logic [WIDTH-1:0]       output_b,
  output logic                   output_b_stb,
  input  logic                   output_b_ack,
  output logic [WIDTH-1:0]       unit_in,
  output logic                   unit_in_stb,
  input  logic                   unit_in_ack,
  input  logic [WIDTH-1:0]       unit_out,
  input  logic                   unit_out_stb,
  output logic                   unit_out_ack,
  output logic                   grant,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] count_a,
  output logic [COUNT_WIDTH-1:0] count_b
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ISSUE,
    ST_COLLECT,
    ST_RETURN
  } state_t;

  state_t                 state_q,      state_d;
  logic                   grant_q,      grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   a_ack_q,      a_ack_d;
  logic                   b_ack_q,      b_ack_d;
  logic [WIDTH-1:0]       op_buf_q,     op_buf_d;
  logic                   uin_stb_q,    uin_stb_d;
  logic                   uout_ack_q,   uout_ack_d;
  logic [WIDTH-1:0]       res_a_q,      res_a_d;
  logic [WIDTH-1:0]       res_b_q,      res_b_d;
  logic                   oa_stb_q,     oa_stb_d;
  logic                   ob_stb_q,     ob_stb_d;
  logic [COUNT_WIDTH-1:0] cnt_a_q,      cnt_a_d;
  logic [COUNT_WIDTH-1:0] cnt_b_q,      cnt_b_d;

  logic pick_b;
  logic in_xfer;
  logic ret_xfer;

  // State and registered handshake outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      op_buf_q     <= '0;
      uin_stb_q    <= 1'b0;
      uout_ack_q   <= 1'b0;
      res_a_q      <= '0;
      res_b_q      <= '0;
      oa_stb_q     <= 1'b0;
      ob_stb_q     <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      op_buf_q     <= op_buf_d;
      uin_stb_q    <= uin_stb_d;
      uout_ack_q   <= uout_ack_d;
      res_a_q      <= res_a_d;
      res_b_q      <= res_b_d;
      oa_stb_q     <= oa_stb_d;
      ob_stb_q     <= ob_stb_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
    end
  end

  // Next-state logic: every register holds unless its state's transfer fires.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    a_ack_d      = a_ack_q;
    b_ack_d      = b_ack_q;
    op_buf_d     = op_buf_q;
    uin_stb_d    = uin_stb_q;
    uout_ack_d   = uout_ack_q;
    res_a_d      = res_a_q;
    res_b_d      = res_b_q;
    oa_stb_d     = oa_stb_q;
    ob_stb_d     = ob_stb_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;

    // On a tie the requester that was not served last wins.
    pick_b   = input_b_stb && (!input_a_stb || !last_grant_q);
    in_xfer  = grant_q ? (input_b_stb && b_ack_q) : (input_a_stb && a_ack_q);
    ret_xfer = grant_q ? (ob_stb_q && output_b_ack) : (oa_stb_q && output_a_ack);

    unique case (state_q)
      ST_IDLE: begin
        if (input_a_stb || input_b_stb) begin
          grant_d = pick_b;
          a_ack_d = !pick_b;
          b_ack_d = pick_b;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_xfer) begin
          op_buf_d  = grant_q ? input_b : input_a;
          a_ack_d   = 1'b0;
          b_ack_d   = 1'b0;
          uin_stb_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (uin_stb_q && unit_in_ack) begin
          uin_stb_d  = 1'b0;
          uout_ack_d = 1'b1;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (uout_ack_q && unit_out_stb) begin
          uout_ack_d = 1'b0;
          if (grant_q) begin
            res_b_d  = unit_out;
            ob_stb_d = 1'b1;
          end else begin
            res_a_d  = unit_out;
            oa_stb_d = 1'b1;
          end
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (ret_xfer) begin
          oa_stb_d     = 1'b0;
          ob_stb_d     = 1'b0;
          last_grant_d = grant_q;
          if (grant_q) cnt_b_d = cnt_b_q + COUNT_WIDTH'(1);
          else         cnt_a_d = cnt_a_q + COUNT_WIDTH'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign unit_in      = op_buf_q;
  assign unit_in_stb  = uin_stb_q;
  assign unit_out_ack = uout_ack_q;
  assign output_a     = res_a_q;
  assign output_b     = res_b_q;
  assign output_a_stb = oa_stb_q;
  assign output_b_stb = ob_stb_q;
  assign grant        = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign count_a      = cnt_a_q;
  assign count_b      = cnt_b_q;

endmodule

// File: tb/tb_fpu_unit_arbiter.sv
// Self-checking bench for fpu_unit_arbiter. Requesters, the shared unit
// (returns operand + 1) and the result consumers are modelled in tick(),
// evaluated once per falling edge. Expected results are queued when an
// operand is handed to a requester and compared as results come back.
module tb_fpu_unit_arbiter;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  input_a, input_b;
  logic          input_a_stb, input_b_stb;
  logic          input_a_ack, input_b_ack;
  logic [W-1:0]  output_a, output_b;
  logic          output_a_stb, output_b_stb;
  logic          output_a_ack, output_b_ack;
  logic [W-1:0]  unit_in;
  logic          unit_in_stb, unit_in_ack;
  logic [W-1:0]  unit_out;
  logic          unit_out_stb, unit_out_ack;
  logic          grant, busy;
  logic [CW-1:0] count_a, count_b;

  fpu_unit_arbiter #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_a(output_a), .output_a_stb(output_a_stb), .output_a_ack(output_a_ack),
    .output_b(output_b), .output_b_stb(output_b_stb), .output_b_ack(output_b_ack),
    .unit_in(unit_in), .unit_in_stb(unit_in_stb), .unit_in_ack(unit_in_ack),
    .unit_out(unit_out), .unit_out_stb(unit_out_stb), .unit_out_ack(unit_out_ack),
    .grant(grant), .busy(busy), .count_a(count_a), .count_b(count_b)
  );

  typedef struct {
    logic         req;
    logic [W-1:0] data;
    logic         gnt;
  } obs_t;

  logic [W-1:0] req_a[$], req_b[$], exp_a[$], exp_b[$];
  obs_t         obs[$];

  int unsigned in_delay, out_delay, cons_a_delay, cons_b_delay;
  int unsigned in_wait, out_wait, ca_wait, cb_wait;
  bit          a_xfer, b_xfer, pend_v;
  logic [W-1:0] pend;
  int unsigned ack_err, drop_err, dual_err, ob_seen, unit_in_xfers, in_stb_hi, out_ack_hi;
  logic        prev_busy, prev_a_ack, prev_b_ack, prev_in_stb, prev_in_ack, prev_out_ack, prev_out_stb;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_models();
    req_a.delete(); req_b.delete(); exp_a.delete(); exp_b.delete(); obs.delete();
    input_a = '0; input_b = '0; input_a_stb = 1'b0; input_b_stb = 1'b0;
    unit_in_ack = 1'b0; unit_out_stb = 1'b0; unit_out = '0;
    output_a_ack = 1'b0; output_b_ack = 1'b0;
    in_delay = 0; out_delay = 0; cons_a_delay = 0; cons_b_delay = 0;
    in_wait = 0; out_wait = 0; ca_wait = 0; cb_wait = 0;
    a_xfer = 1'b0; b_xfer = 1'b0; pend_v = 1'b0; pend = '0;
    ack_err = 0; drop_err = 0; dual_err = 0; ob_seen = 0;
    unit_in_xfers = 0; in_stb_hi = 0; out_ack_hi = 0;
    prev_busy = 1'b0; prev_a_ack = 1'b0; prev_b_ack = 1'b0; prev_in_stb = 1'b0;
    prev_in_ack = 1'b0; prev_out_ack = 1'b0; prev_out_stb = 1'b0;
  endtask

  // One clock of all environment models, evaluated at the falling edge.
  task automatic tick();
    @(negedge clk);
    // protocol monitors
    if (prev_busy && ((input_a_ack && !prev_a_ack) || (input_b_ack && !prev_b_ack))) ack_err++;
    if (input_a_ack && input_b_ack) dual_err++;
    if (output_a_stb && output_b_stb) dual_err++;
    if (output_b_stb) ob_seen++;
    if (prev_in_stb && !prev_in_ack && !unit_in_stb) drop_err++;
    if (prev_out_ack && !prev_out_stb && !unit_out_ack) drop_err++;
    if (unit_in_stb) in_stb_hi++;
    if (unit_out_ack) out_ack_hi++;
    // unit result side (a raised stb with ack now low means it transferred)
    if (unit_out_stb) begin
      if (!unit_out_ack) begin unit_out_stb = 1'b0; pend_v = 1'b0; out_wait = 0; end
    end else if (pend_v && unit_out_ack) begin
      if (out_wait >= out_delay) begin unit_out = pend; unit_out_stb = 1'b1; end
      else out_wait++;
    end
    // unit operand side
    if (unit_in_ack) begin
      unit_in_ack = 1'b0; in_wait = 0;
    end else if (unit_in_stb) begin
      if (in_wait >= in_delay) begin
        unit_in_ack = 1'b1; pend = unit_in + 64'd1; pend_v = 1'b1; unit_in_xfers++;
      end else in_wait++;
    end
    // consumers
    if (output_a_ack) begin output_a_ack = 1'b0; ca_wait = 0; end
    else if (output_a_stb) begin
      if (ca_wait >= cons_a_delay) begin output_a_ack = 1'b1; obs.push_back('{1'b0, output_a, grant}); end
      else ca_wait++;
    end
    if (output_b_ack) begin output_b_ack = 1'b0; cb_wait = 0; end
    else if (output_b_stb) begin
      if (cb_wait >= cons_b_delay) begin output_b_ack = 1'b1; obs.push_back('{1'b1, output_b, grant}); end
      else cb_wait++;
    end
    // requesters: hold stb/data until the transfer edge, then present the next operand
    if (a_xfer) begin a_xfer = 1'b0; input_a_stb = 1'b0; end
    if (!input_a_stb && req_a.size() != 0) begin input_a = req_a.pop_front(); input_a_stb = 1'b1; end
    if (input_a_stb && input_a_ack) a_xfer = 1'b1;
    if (b_xfer) begin b_xfer = 1'b0; input_b_stb = 1'b0; end
    if (!input_b_stb && req_b.size() != 0) begin input_b = req_b.pop_front(); input_b_stb = 1'b1; end
    if (input_b_stb && input_b_ack) b_xfer = 1'b1;
    prev_busy = busy; prev_a_ack = input_a_ack; prev_b_ack = input_b_ack;
    prev_in_stb = unit_in_stb; prev_in_ack = unit_in_ack;
    prev_out_ack = unit_out_ack; prev_out_stb = unit_out_stb;
  endtask

  task automatic wait_done(input int unsigned n, output bit ok);
    int unsigned c = 0;
    ok = 1'b0;
    while (c < 2000) begin
      tick();
      c++;
      if (obs.size() >= n && !busy && req_a.size() == 0 && req_b.size() == 0 &&
          !input_a_stb && !input_b_stb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_models();
    #1;
    n_checks++;
    if ({input_a_ack, input_b_ack, unit_in_stb, unit_out_ack, output_a_stb, output_b_stb, busy, grant} !== 8'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000000",
        {input_a_ack, input_b_ack, unit_in_stb, unit_out_ack, output_a_stb, output_b_stb, busy, grant});
    end
    n_checks++;
    if ({count_a, count_b} !== '0) begin
      n_fail++; $display("FAIL reset_counts: got a=%0d b=%0d want 0 0", count_a, count_b);
    end
    n_checks++;
    if ({output_a, output_b, unit_in} !== '0) begin
      n_fail++; $display("FAIL reset_data: got a=%h b=%h u=%h want 0", output_a, output_b, unit_in);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // stray unit strobes in IDLE must be ignored
    unit_in_ack = 1'b1; unit_out_stb = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, unit_out_ack, unit_in_stb, output_a_stb, output_b_stb} !== 5'b0) begin
      n_fail++; $display("FAIL stray_strobe: got %b want 00000",
        {busy, unit_out_ack, unit_in_stb, output_a_stb, output_b_stb});
    end
    clear_models();
  endtask

  task automatic test_single();
    do_reset();
    req_a.push_back(64'h5); exp_a.push_back(64'h6);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) begin
        n_checks++;
        if ({input_a_ack, busy, grant} !== 3'b110) begin
          n_fail++; $display("FAIL single_ack_edge0: got %b want 110", {input_a_ack, busy, grant});
        end
      end
      if (c == 4) begin
        n_checks++;
        if (output_a_stb !== 1'b0) begin
          n_fail++; $display("FAIL single_stb_edge2: got %b want 0", output_a_stb);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (output_a_stb !== 1'b1 || output_a !== 64'h6) begin
          n_fail++; $display("FAIL single_out_edge3: got stb=%b data=%h want 1 6", output_a_stb, output_a);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (busy !== 1'b0 || count_a !== 4'd1 || count_b !== 4'd0) begin
          n_fail++; $display("FAIL single_done: got busy=%b a=%0d b=%0d want 0 1 0", busy, count_a, count_b);
        end
      end
    end
    n_checks++;
    if (ob_seen != 0 || obs.size() != 1) begin
      n_fail++; $display("FAIL single_b_quiet: got ob_seen=%0d results=%0d want 0 1", ob_seen, obs.size());
    end else begin
      n_checks++;
      if (obs[0].req !== 1'b0 || obs[0].data !== exp_a.pop_front()) begin
        n_fail++; $display("FAIL single_result: got req=%b data=%h want 0 6", obs[0].req, obs[0].data);
      end
    end
  endtask

  task automatic test_tie();
    bit ok;
    do_reset();
    req_a.push_back(64'h11); exp_a.push_back(64'h12);
    req_b.push_back(64'h22); exp_b.push_back(64'h23);
    wait_done(2, ok);
    n_checks++;
    if (!ok || obs.size() != 2) begin
      n_fail++; $display("FAIL tie_timeout: got results=%0d want 2", obs.size());
    end else begin
      n_checks++;
      if (obs[0].req !== 1'b0 || obs[0].gnt !== 1'b0 || obs[0].data !== exp_a.pop_front()) begin
        n_fail++; $display("FAIL tie_first: got req=%b gnt=%b data=%h want 0 0 12", obs[0].req, obs[0].gnt, obs[0].data);
      end
      n_checks++;
      if (obs[1].req !== 1'b1 || obs[1].gnt !== 1'b1 || obs[1].data !== exp_b.pop_front()) begin
        n_fail++; $display("FAIL tie_second: got req=%b gnt=%b data=%h want 1 1 23", obs[1].req, obs[1].gnt, obs[1].data);
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [W-1:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_a.push_back(64'h100 + 64'(i)); exp_a.push_back(64'h101 + 64'(i));
      req_b.push_back(64'h200 + 64'(i)); exp_b.push_back(64'h201 + 64'(i));
    end
    wait_done(10, ok);
    n_checks++;
    if (!ok || obs.size() != 10) begin
      n_fail++; $display("FAIL fair_timeout: got results=%0d want 10", obs.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        e = (i % 2 == 0) ? exp_a.pop_front() : exp_b.pop_front();
        n_checks++;
        if (obs[i].req !== 1'(i % 2) || obs[i].gnt !== 1'(i % 2) || obs[i].data !== e) begin
          n_fail++; $display("FAIL fair_order[%0d]: got req=%b gnt=%b data=%h want %0d %0d %h",
            i, obs[i].req, obs[i].gnt, obs[i].data, i % 2, i % 2, e);
        end
      end
    end
    n_checks++;
    if (count_a !== 4'd5 || count_b !== 4'd5) begin
      n_fail++; $display("FAIL fair_counts: got a=%0d b=%0d want 5 5", count_a, count_b);
    end
    n_checks++;
    if (ack_err != 0 || dual_err != 0 || unit_in_xfers != 10) begin
      n_fail++; $display("FAIL fair_protocol: got ack_err=%0d dual=%0d unit_xfers=%0d want 0 0 10",
        ack_err, dual_err, unit_in_xfers);
    end
  endtask

  task automatic test_stalls();
    bit ok;
    do_reset();
    in_delay = 4; out_delay = 6; cons_b_delay = 3;
    req_b.push_back(64'h1234); exp_b.push_back(64'h1235);
    wait_done(1, ok);
    n_checks++;
    if (!ok || obs.size() != 1) begin
      n_fail++; $display("FAIL stall_timeout: got results=%0d want 1", obs.size());
    end else begin
      n_checks++;
      if (obs[0].req !== 1'b1 || obs[0].data !== exp_b.pop_front()) begin
        n_fail++; $display("FAIL stall_result: got req=%b data=%h want 1 1235", obs[0].req, obs[0].data);
      end
    end
    n_checks++;
    if (in_stb_hi != 5 || out_ack_hi != 7 || ob_seen != 4) begin
      n_fail++; $display("FAIL stall_hold: got in_stb=%0d out_ack=%0d out_b_stb=%0d want 5 7 4",
        in_stb_hi, out_ack_hi, ob_seen);
    end
    n_checks++;
    if (drop_err != 0 || unit_in_xfers != 1 || count_b !== 4'd1 || count_a !== 4'd0) begin
      n_fail++; $display("FAIL stall_dup: got drop=%0d unit_xfers=%0d a=%0d b=%0d want 0 1 0 1",
        drop_err, unit_in_xfers, count_a, count_b);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found = 1'b0;
    do_reset();
    out_delay = 20;
    req_b.push_back(64'h40);
    for (int c = 0; c < 50 && !found; c++) begin
      tick();
      if (unit_out_ack && grant) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL mid_reach_collect: got unit_out_ack=%b grant=%b want 1 1", unit_out_ack, grant);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({input_a_ack, input_b_ack, unit_in_stb, unit_out_ack, output_a_stb, output_b_stb, busy} !== 7'b0) begin
      n_fail++; $display("FAIL mid_abort: got %b want 0000000",
        {input_a_ack, input_b_ack, unit_in_stb, unit_out_ack, output_a_stb, output_b_stb, busy});
    end
    n_checks++;
    if (count_b !== 4'd0) begin
      n_fail++; $display("FAIL mid_count: got %0d want 0", count_b);
    end
    clear_models();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_b.push_back(64'h40); exp_b.push_back(64'h41);
    wait_done(1, ok);
    n_checks++;
    if (!ok || obs.size() != 1) begin
      n_fail++; $display("FAIL mid_retry_timeout: got results=%0d want 1", obs.size());
    end else begin
      n_checks++;
      if (obs[0].req !== 1'b1 || obs[0].data !== exp_b.pop_front() || count_b !== 4'd1) begin
        n_fail++; $display("FAIL mid_retry: got req=%b data=%h count_b=%0d want 1 41 1",
          obs[0].req, obs[0].data, count_b);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int unsigned bad = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      req_a.push_back(64'h1000 + 64'(i)); exp_a.push_back(64'h1001 + 64'(i));
    end
    wait_done(17, ok);
    n_checks++;
    if (!ok || obs.size() != 17) begin
      n_fail++; $display("FAIL wrap_timeout: got results=%0d want 17", obs.size());
    end else begin
      foreach (obs[i]) if (obs[i].req !== 1'b0 || obs[i].data !== exp_a.pop_front()) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL wrap_results: got %0d bad results want 0", bad);
      end
    end
    n_checks++;
    if (count_a !== 4'd1 || count_b !== 4'd0) begin
      n_fail++; $display("FAIL wrap_count: got a=%0d b=%0d want 1 0", count_a, count_b);
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_models();
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_stalls();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
